fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
Parametrised successor to the pipeline forwarding logic. It generates bypass selects for NUM_SRC source operands in EX, and adds a per-register latency scoreboard. The scoreboard stalls ID when a source is produced by a multi-cycle or load instruction that cannot yet be bypassed. It sits between the ID/EX pipeline control and the EX operand muxes.

Parameters:
AW, 5, register address width; scoreboard has 2**AW entries.
NUM_SRC, 2, source operands per instruction.
MAX_LAT, 8, largest producer latency tracked, in cycles.
CW, 4, counter width; must satisfy 2**CW > MAX_LAT.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
flush  in  1  pipeline flush; clears the scoreboard.
id_issue  in  1  ID instruction attempts to advance to EX this cycle.
id_we  in  1  issuing instruction writes a register.
id_rd  in  AW  destination register of the issuing instruction.
id_lat  in  CW  stall cycles a consumer needs after issue (ALU=0, load=1, mul=3, ...).
id_src  in  NUM_SRC*AW  ID source registers; source i occupies bits [i*AW +: AW].
id_src_used  in  NUM_SRC  bit i set = source i is actually read.
ex_src  in  NUM_SRC*AW  EX source registers (the former rs/rt), packed the same way.
exmem_rw  in  AW  EX/MEM destination register.
exmem_regwrite  in  1  EX/MEM write enable.
memwb_rw  in  AW  MEM/WB destination register.
memwb_regwrite  in  1  MEM/WB write enable.
forward_sel  out  2*NUM_SRC  per-source bypass select, bits [2i +: 2].
stall  out  1  hold IF/ID and insert a bubble into EX.
busy  out  1  at least one scoreboard counter is nonzero.

Behaviour:
- Reset: every cnt[r] becomes 0 at the next clk edge. Afterwards stall=0 and busy=0. forward_sel is combinational and takes no reset state.
- Forward select, per source i, combinational, with priority in this order:
  - exmem_regwrite && exmem_rw!=0 && exmem_rw==ex_src[i] gives 2'b01.
  - memwb_regwrite && memwb_rw!=0 && memwb_rw==ex_src[i] gives 2'b10.
  - Otherwise 2'b00.
- The EX/MEM match wins over MEM/WB: the newest value has priority.
- stall, combinational from registered counters only: OR over i of (id_src_used[i] && id_src[i]!=0 && cnt[id_src[i]]!=0).
- Accepted issue: acc = id_issue && !stall && !flush.
- Counter update on each clk edge, in priority order:
  1. rst or flush: all cnt cleared to 0.
  2. For every r: if cnt[r]!=0, cnt[r] decrements by 1.
  3. If acc && id_we && id_rd!=0: cnt[id_rd] loads min(id_lat, MAX_LAT). This overrides the decrement of the same entry, so a newer producer replaces the older one.
- Register 0 is never tracked: cnt[0] stays 0 permanently.
- Latency: a consumer decoded in the cycle after its producer issues stalls exactly id_lat cycles. The stall deasserts in the cycle the counter reads 0.
- id_lat=0 leaves the counter at 0. No stall occurs; normal bypass covers the dependency.
- A stalled instruction never updates the scoreboard, even if id_issue=1.
- flush together with an issue: flush wins, and the issuing instruction is not recorded.
- rst asserted mid-stall: stall drops in the cycle after the reset edge.
- busy: OR of all cnt[r]!=0.

Optional Feature:
FWD_STALL_STATS_EN:
- Defined:
  - Adds output stall_cycles (32 bits).
  - The counter increments on every clk edge where stall=1, and saturates at 32'hFFFF_FFFF.
  - rst clears it; flush does not.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- exmem_regwrite=1, exmem_rw=5, memwb_regwrite=1, memwb_rw=5, ex_src[0]=5 -> forward_sel[1:0]=2'b01 (EX/MEM priority). With exmem_rw=0 instead -> 2'b10.
- Issue load: id_rd=8, id_lat=1. Next cycle id_src[0]=8, id_src_used[0]=1 -> stall=1 for exactly 1 cycle, then 0.
- Issue mul: id_rd=3, id_lat=3. Consumer of r3 held -> stall high 3 consecutive cycles. busy falls in the same cycle stall falls.
- Issue r3 with id_lat=3; one cycle later issue r3 with id_lat=0 (ALU overwrite) -> cnt[3]=0, no stall for a subsequent r3 consumer.
- Issue id_rd=9, id_lat=5, then assert flush after 2 cycles -> stall and busy drop the next cycle. flush+id_issue in the same cycle leaves cnt[rd]=0.
- id_rd=0 with id_lat=4 -> no stall for a source-0 consumer. id_lat=15 with MAX_LAT=8 -> stall lasts exactly 8 cycles.

Source files
------------

// File: rtl/fwd_hazard_if.sv
// Bundle of ID/EX control and bypass signals between the pipeline and fwd_hazard_unit.
// The stall_cycles output exists only when FWD_STALL_STATS_EN is defined.
interface fwd_hazard_if #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int CW      = 4
) ();
  logic                   flush;
  logic                   id_issue;
  logic                   id_we;
  logic [AW-1:0]          id_rd;
  logic [CW-1:0]          id_lat;
  logic [NUM_SRC*AW-1:0]  id_src;
  logic [NUM_SRC-1:0]     id_src_used;
  logic [NUM_SRC*AW-1:0]  ex_src;
  logic [AW-1:0]          exmem_rw;
  logic                   exmem_regwrite;
  logic [AW-1:0]          memwb_rw;
  logic                   memwb_regwrite;
  logic [2*NUM_SRC-1:0]   forward_sel;
  logic                   stall;
  logic                   busy;
`ifdef FWD_STALL_STATS_EN
  logic [31:0]            stall_cycles;

  modport master (
    output flush, id_issue, id_we, id_rd, id_lat, id_src, id_src_used, ex_src,
           exmem_rw, exmem_regwrite, memwb_rw, memwb_regwrite,
    input  forward_sel, stall, busy, stall_cycles
  );
  modport slave (
    input  flush, id_issue, id_we, id_rd, id_lat, id_src, id_src_used, ex_src,
           exmem_rw, exmem_regwrite, memwb_rw, memwb_regwrite,
    output forward_sel, stall, busy, stall_cycles
  );
`else
  modport master (
    output flush, id_issue, id_we, id_rd, id_lat, id_src, id_src_used, ex_src,
           exmem_rw, exmem_regwrite, memwb_rw, memwb_regwrite,
    input  forward_sel, stall, busy
  );
  modport slave (
    input  flush, id_issue, id_we, id_rd, id_lat, id_src, id_src_used, ex_src,
           exmem_rw, exmem_regwrite, memwb_rw, memwb_regwrite,
    output forward_sel, stall, busy
  );
`endif
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX bypass select generation plus a per-register latency scoreboard that stalls ID.
// Optional FWD_STALL_STATS_EN adds a saturating count of stalled cycles.
module fwd_hazard_unit #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int MAX_LAT = 8,
  parameter int CW      = 4
) (
  input  logic        clk,
  input  logic        rst,
  fwd_hazard_if.slave bus
);
  localparam int              NREG    = 1 << AW;
  localparam logic [CW-1:0]   LAT_CAP = CW'(MAX_LAT);

  // Handshake: an instruction advances from ID to EX only when id_issue=1 and
  // stall=0 in the same cycle (and no flush); only then is it recorded.
  logic [CW-1:0]        cnt [NREG];
  logic                 stall_int;
  logic                 busy_int;
  logic                 acc;
  logic [CW-1:0]        lat_clamped;
  logic [2*NUM_SRC-1:0] fwd;

  function automatic logic [1:0] fwd_pick(
    input logic [AW-1:0] src,
    input logic          em_we,
    input logic [AW-1:0] em_rw,
    input logic          mw_we,
    input logic [AW-1:0] mw_rw
  );
    // The EX/MEM stage holds the newer result, so it is checked first.
    if (em_we && em_rw != '0 && em_rw == src)      return 2'b01;
    else if (mw_we && mw_rw != '0 && mw_rw == src) return 2'b10;
    else                                           return 2'b00;
  endfunction

  always_comb begin
    fwd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd[2*i +: 2] = fwd_pick(bus.ex_src[i*AW +: AW],
                               bus.exmem_regwrite, bus.exmem_rw,
                               bus.memwb_regwrite, bus.memwb_rw);
    end
  end

  always_comb begin
    stall_int = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_used[i] && bus.id_src[i*AW +: AW] != '0 &&
          cnt[bus.id_src[i*AW +: AW]] != '0)
        stall_int = 1'b1;
    end
  end

  always_comb begin
    busy_int = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (cnt[r] != '0) busy_int = 1'b1;
    end
  end

  assign lat_clamped = (bus.id_lat > LAT_CAP) ? LAT_CAP : bus.id_lat;
  assign acc         = bus.id_issue && !stall_int && !bus.flush;

  // A new producer overrides the decrement of its own entry; r0 is never loaded.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (cnt[r] != '0) cnt[r] <= cnt[r] - CW'(1);
      end
      if (acc && bus.id_we && bus.id_rd != '0)
        cnt[bus.id_rd] <= lat_clamped;
    end
  end

`ifdef FWD_STALL_STATS_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles_q <= '0;
    else if (stall_int && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  assign bus.stall_cycles = stall_cycles_q;
`endif

  assign bus.forward_sel = fwd;
  assign bus.stall       = stall_int;
  assign bus.busy        = busy_int;
endmodule
